noekeon_core: RTL and testbench



---
 rtl/noekeon_core.sv | 157 +++++++++++++++
 tb/tb_noekeon_core.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/noekeon_core.sv
// Iterative NOEKEON engine in direct-key mode: one round per clock for NR rounds,
// then the output theta, with valid/ready handshakes on both the input and output sides.
module noekeon_core #(
  parameter int unsigned KEY_SIZE   = 128,
  parameter int unsigned BLOCK_SIZE = 128,
  parameter int unsigned NR         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [KEY_SIZE-1:0]   k_in,
  input  logic [BLOCK_SIZE-1:0] a_in,
  output logic [BLOCK_SIZE-1:0] a_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  localparam int unsigned RCW    = BLOCK_SIZE / 16;
  localparam int unsigned CW     = (NR > 1) ? $clog2(NR) : 1;
  localparam int unsigned W0_LSB = BLOCK_SIZE - 32;

  typedef logic [BLOCK_SIZE-1:0] blk_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  state_e           st_q, st_d;
  blk_t             blk_q, blk_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [RCW-1:0]   rc_q, rc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  blk_t             aout_q, aout_d;
  logic             valid_q, valid_d;

  function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Round constants land in the low byte of word 0, which is the most significant word.
  function automatic blk_t put_rc(input logic [RCW-1:0] rc);
    blk_t v;
    v = '0;
    v[W0_LSB +: RCW] = rc;
    return v;
  endfunction

  function automatic blk_t theta(input blk_t k, input blk_t a);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = a;
    t  = w0 ^ w2;
    t  = t ^ rol(t, 8) ^ rol(t, 24);
    w1 = w1 ^ t;
    w3 = w3 ^ t;
    {w0, w1, w2, w3} = {w0, w1, w2, w3} ^ k;
    t  = w1 ^ w3;
    t  = t ^ rol(t, 8) ^ rol(t, 24);
    return {w0 ^ t, w1, w2 ^ t, w3};
  endfunction

  // Pi1, Gamma and Pi2 fused into one pass.
  function automatic blk_t gamma_pi(input blk_t a);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = a;
    w1 = rol(w1, 1);
    w2 = rol(w2, 5);
    w3 = rol(w3, 2);
    w1 = w1 ^ (~w3 & ~w2);
    w0 = w0 ^ (w2 & w1);
    t  = w3;
    w3 = w0;
    w0 = t;
    w2 = w2 ^ w0 ^ w1 ^ w3;
    w1 = w1 ^ (~w3 & ~w2);
    w0 = w0 ^ (w2 & w1);
    return {w0, rol(w1, 31), rol(w2, 27), rol(w3, 30)};
  endfunction

  function automatic logic [RCW-1:0] rc_fwd(input logic [RCW-1:0] rc);
    return {rc[RCW-2:0], 1'b0} ^ (rc[RCW-1] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [RCW-1:0] rc_bwd(input logic [RCW-1:0] rc);
    return rc[0] ? ({1'b1, rc[RCW-1:1]} ^ 8'h0D) : {1'b0, rc[RCW-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      aout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      aout_q  <= aout_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    blk_d   = blk_q;
    key_d   = key_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    aout_d  = aout_q;
    valid_d = valid_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          blk_d  = a_in;
          mode_d = mode;
          cnt_d  = '0;
          key_d  = mode ? theta('0, k_in) : k_in;
          rc_d   = mode ? 8'hD4 : 8'h80;
          st_d   = ROUND;
        end
      end
      ROUND: begin
        blk_d = gamma_pi(theta(key_q, blk_q ^ put_rc(mode_q ? '0 : rc_q))
                         ^ put_rc(mode_q ? rc_q : '0));
        rc_d  = mode_q ? rc_bwd(rc_q) : rc_fwd(rc_q);
        if (cnt_q == CW'(NR - 1)) st_d = FINAL;
        else cnt_d = cnt_q + 1'b1;
      end
      FINAL: begin
        aout_d  = mode_q ? (theta(key_q, blk_q) ^ put_rc(rc_q))
                         : theta(key_q, blk_q ^ put_rc(rc_q));
        valid_d = 1'b1;
        st_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          st_d    = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign in_ready  = (st_q == IDLE);
  assign busy      = (st_q == ROUND) || (st_q == FINAL);
  assign a_out     = aout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_noekeon_core.sv
// Self-checking bench for noekeon_core: word-level NOEKEON reference model plus a
// transaction-level handshake model, compared against the DUT on every cycle.
module tb_noekeon_core;
  typedef logic [0:3][31:0] wblk_t;

  logic         clk = 1'b0;
  logic         rst, start, mode, out_ready;
  logic [127:0] k_in, a_in;
  logic         in_ready, out_valid, busy;
  logic [127:0] a_out;

  always #5 clk = ~clk;

  noekeon_core #(.KEY_SIZE(128), .BLOCK_SIZE(128), .NR(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .mode(mode),
    .k_in(k_in), .a_in(a_in), .a_out(a_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  localparam logic [127:0] CT0  = 128'hb1656851_699e29fa_24b70148_503d2dfc;
  localparam logic [127:0] CT1  = 128'h2a78421b_87c7d092_4f26113f_1d1349b2;
  localparam logic [127:0] ONES = {128{1'b1}};
  logic [7:0] exp_rc [17] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
                              8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};
  logic [7:0] rc_seen [18];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference cipher, word-array form ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [7:0] rc_tab(input int n);
    logic [7:0] r;
    r = 8'h80;
    for (int i = 0; i < n; i++) r = (r << 1) ^ (r[7] ? 8'h1B : 8'h00);
    return r;
  endfunction

  function automatic wblk_t theta_m(input wblk_t k, input wblk_t a);
    logic [31:0] t;
    t = a[0] ^ a[2];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[1] ^= t;
    a[3] ^= t;
    for (int i = 0; i < 4; i++) a[i] ^= k[i];
    t = a[1] ^ a[3];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[0] ^= t;
    a[2] ^= t;
    return a;
  endfunction

  function automatic wblk_t gamma_m(input wblk_t a);
    logic [31:0] t;
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    t = a[3]; a[3] = a[0]; a[0] = t;
    a[2] ^= a[0] ^ a[1] ^ a[3];
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    return a;
  endfunction

  function automatic wblk_t round_m(input wblk_t k, input wblk_t a, input logic [7:0] rc1,
                                    input logic [7:0] rc2);
    a[0] ^= {24'h0, rc1};
    a = theta_m(k, a);
    a[0] ^= {24'h0, rc2};
    a[1] = rl(a[1], 1);  a[2] = rl(a[2], 5);  a[3] = rl(a[3], 2);
    a = gamma_m(a);
    a[1] = rl(a[1], 31); a[2] = rl(a[2], 27); a[3] = rl(a[3], 30);
    return a;
  endfunction

  function automatic logic [127:0] enc_m(input logic [127:0] k, input logic [127:0] x);
    wblk_t a, kk;
    a = x;
    kk = k;
    for (int r = 0; r < 16; r++) a = round_m(kk, a, rc_tab(r), 8'h00);
    a[0] ^= {24'h0, rc_tab(16)};
    a = theta_m(kk, a);
    return a;
  endfunction

  function automatic logic [127:0] dec_m(input logic [127:0] k, input logic [127:0] x);
    wblk_t a, wk;
    a = x;
    wk = theta_m('0, k);
    for (int r = 16; r >= 1; r--) a = round_m(wk, a, 8'h00, rc_tab(r));
    a = theta_m(wk, a);
    a[0] ^= {24'h0, rc_tab(0)};
    return a;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- transaction model ----------------
  logic         m_idle, m_valid;
  logic [127:0] m_aout, m_res;
  int           m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_aout  <= '0;
      m_cnt   <= 0;
    end else if (m_idle) begin
      if (start) begin
        m_idle <= 1'b0;
        m_cnt  <= 0;
        m_res  <= mode ? dec_m(k_in, a_in) : enc_m(k_in, a_in);
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_idle  <= 1'b1;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 16) begin
        m_valid <= 1'b1;
        m_aout  <= m_res;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  128'(in_ready),  128'(m_idle));
      check("busy",      128'(busy),      128'(!m_idle && !m_valid));
      check("out_valid", 128'(out_valid), 128'(m_valid));
      check("a_out",     a_out,           m_aout);
    end
  end

  // Entered at posedge+2 with the DUT idle; leaves at posedge+2 just after the output transfer.
  task automatic do_op(input logic md, input logic [127:0] k, input logic [127:0] x,
                       input int hold, output logic [127:0] res);
    int lat;
    start = 1'b1; mode = md; k_in = k; a_in = x;
    @(posedge clk); #2;
    start = 1'b0; mode = 1'($urandom); k_in = rnd128(); a_in = rnd128();
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat < 18) rc_seen[lat] = dut.rc_q;
      if (out_valid) break;
    end
    check("latency", 128'(lat), 128'(18));
    res = a_out;
    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom); k_in = rnd128(); a_in = rnd128();
      @(posedge clk); #2;
    end
    start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  logic [127:0] r, p, x, k;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; k_in = '0; a_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_a_out", a_out, 128'(0));
    @(posedge clk); #2;

    check("model_enc0", enc_m('0, '0), CT0);
    check("model_enc1", enc_m(ONES, ONES), CT1);
    check("model_dec0", dec_m('0, CT0), 128'(0));

    do_op(1'b0, '0, '0, 0, r);
    check("enc_zero", r, CT0);
    for (int i = 0; i < 17; i++) check("rc_enc", 128'(rc_seen[i+1]), 128'(exp_rc[i]));
    do_op(1'b0, ONES, ONES, 0, r);
    check("enc_ones", r, CT1);
    do_op(1'b1, '0, CT0, 0, r);
    check("dec_zero", r, 128'(0));
    for (int i = 0; i < 17; i++) check("rc_dec", 128'(rc_seen[i+1]), 128'(exp_rc[16-i]));
    do_op(1'b1, ONES, CT1, 0, r);
    check("dec_ones", r, ONES);

    // stall in DONE with noisy inputs, then a back-to-back accept
    k = rnd128(); x = rnd128();
    do_op(1'b0, k, x, 10, r);
    do_op(1'b1, k, r, 0, p);
    check("hold_roundtrip", p, x);

    // reset during round cycle 7
    start = 1'b1; mode = 1'b0; k_in = rnd128(); a_in = rnd128();
    @(posedge clk); #2;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    @(posedge clk); #2;
    do_op(1'b0, '0, '0, 0, r);
    check("post_rst_enc", r, CT0);

    for (int n = 0; n < 50; n++) begin
      k = rnd128(); x = rnd128();
      do_op(1'b0, k, x, $urandom_range(0, 3), r);
      do_op(1'b1, k, r, $urandom_range(0, 3), p);
      check("rand_roundtrip", p, x);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
